clock_alarm: RTL and testbench

//   Alarm engine on the consumer side of the 12-hour BCD time bus (pm, hh, mm, ss) driven by the timekeeper.

---
 rtl/clock_alarm_pkg.sv | 27 ++
 rtl/bcd_time_decode.sv | 24 ++
 rtl/clock_alarm.sv | 186 ++++++++++++++++++
 tb/tb_clock_alarm.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_alarm_pkg.sv
// Shared state encoding, time limits and BCD helpers for the 12-hour alarm engine.
package clock_alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RINGING = 2'd2,
        ST_SNOOZE  = 2'd3
    } state_t;

    localparam int unsigned MAX_HOUR = 11;
    localparam int unsigned MAX_MIN  = 59;
    localparam int unsigned MAX_SEC  = 59;

    function automatic logic [7:0] bcd_to_bin(input logic [7:0] bcd);
        return 8'(bcd[7:4]) * 8'd10 + 8'(bcd[3:0]);
    endfunction

    function automatic logic [7:0] bin_to_bcd(input logic [6:0] bin);
        return {4'(bin / 7'd10), 4'(bin % 7'd10)};
    endfunction

    function automatic logic bcd_ok(input logic [7:0] bcd, input int unsigned lim);
        return (bcd[7:4] <= 4'd9) && (bcd[3:0] <= 4'd9) && (32'(bcd_to_bin(bcd)) <= lim);
    endfunction

endpackage

// File: rtl/bcd_time_decode.sv
// Validates one {pm,hh,mm,ss} BCD bundle and converts it to binary fields.
module bcd_time_decode
    import clock_alarm_pkg::*;
(
    input  logic       i_pm,
    input  logic [7:0] i_hh,
    input  logic [7:0] i_mm,
    input  logic [7:0] i_ss,
    output logic       o_pm,
    output logic [3:0] o_hh,
    output logic [5:0] o_mm,
    output logic [5:0] o_ss,
    output logic       o_valid
);

    always_comb begin
        o_pm    = i_pm;
        o_hh    = 4'(bcd_to_bin(i_hh));
        o_mm    = 6'(bcd_to_bin(i_mm));
        o_ss    = 6'(bcd_to_bin(i_ss));
        o_valid = bcd_ok(i_hh, MAX_HOUR) && bcd_ok(i_mm, MAX_MIN) && bcd_ok(i_ss, MAX_SEC);
    end

endmodule

// File: rtl/clock_alarm.sv
// Alarm engine on the 12-hour BCD time bus: alarm load, match, ring timeout, snooze.
// Optional hourly chime output enabled by defining CLOCK_ALARM_HOURLY_CHIME_EN.
module clock_alarm
    import clock_alarm_pkg::*;
#(
    parameter int unsigned RING_SECS  = 60,
    parameter int unsigned SNOOZE_MIN = 5
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ena,
    input  logic       i_pm,
    input  logic [7:0] i_hh,
    input  logic [7:0] i_mm,
    input  logic [7:0] i_ss,
    input  logic       i_set_valid,
    input  logic [7:0] i_set_hh,
    input  logic [7:0] i_set_mm,
    input  logic       i_set_pm,
    output logic       o_set_ready,
    output logic       o_set_err,
    input  logic       i_arm,
    input  logic       i_stop,
    input  logic       i_snooze,
    output logic       o_ring,
    output logic [1:0] o_state,
    output logic [7:0] o_alarm_hh,
    output logic [7:0] o_alarm_mm,
    output logic       o_alarm_pm
`ifdef CLOCK_ALARM_HOURLY_CHIME_EN
    ,
    output logic       o_chime
`endif
);

    localparam int unsigned CW = $clog2(RING_SECS + 1);

    state_t       r_state;
    logic         r_ring, r_set_err;
    logic [CW-1:0] r_cnt;
    logic         r_al_pm, r_snz_pm;
    logic [3:0]   r_al_hh, r_snz_hh;
    logic [5:0]   r_al_mm, r_snz_mm;

    logic         w_cur_pm, w_cur_valid;
    logic [3:0]   w_cur_hh;
    logic [5:0]   w_cur_mm, w_cur_ss;
    logic         w_tick_ok, w_alarm_hit, w_snz_hit, w_ready;
    logic [6:0]   w_mm_sum;
    logic         w_nxt_pm;
    logic [3:0]   w_nxt_hh;
    logic [5:0]   w_nxt_mm;

    bcd_time_decode u_cur (
        .i_pm    (i_pm),
        .i_hh    (i_hh),
        .i_mm    (i_mm),
        .i_ss    (i_ss),
        .o_pm    (w_cur_pm),
        .o_hh    (w_cur_hh),
        .o_mm    (w_cur_mm),
        .o_ss    (w_cur_ss),
        .o_valid (w_cur_valid)
    );

    always_comb begin
        w_tick_ok   = i_ena && w_cur_valid && (w_cur_ss == '0);
        w_alarm_hit = w_tick_ok && ({w_cur_pm, w_cur_hh, w_cur_mm} == {r_al_pm, r_al_hh, r_al_mm});
        w_snz_hit   = w_tick_ok && ({w_cur_pm, w_cur_hh, w_cur_mm} == {r_snz_pm, r_snz_hh, r_snz_mm});
        w_ready     = (r_state == ST_IDLE) || (r_state == ST_ARMED);
    end

    // Snooze target: minute overflow carries into the hour, hour 11 wraps to 0 and flips AM/PM.
    always_comb begin
        w_mm_sum = 7'(w_cur_mm) + 7'(SNOOZE_MIN);
        w_nxt_pm = w_cur_pm;
        w_nxt_hh = w_cur_hh;
        w_nxt_mm = 6'(w_mm_sum);
        if (w_mm_sum > 7'(MAX_MIN)) begin
            w_nxt_mm = 6'(w_mm_sum - 7'd60);
            if (w_cur_hh == 4'(MAX_HOUR)) begin
                w_nxt_hh = '0;
                w_nxt_pm = ~w_cur_pm;
            end else begin
                w_nxt_hh = w_cur_hh + 4'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_al_pm   <= 1'b0;
            r_al_hh   <= '0;
            r_al_mm   <= '0;
            r_set_err <= 1'b0;
        end else begin
            r_set_err <= 1'b0;
            if (i_set_valid && w_ready) begin
                if (bcd_ok(i_set_hh, MAX_HOUR) && bcd_ok(i_set_mm, MAX_MIN)) begin
                    r_al_pm <= i_set_pm;
                    r_al_hh <= 4'(bcd_to_bin(i_set_hh));
                    r_al_mm <= 6'(bcd_to_bin(i_set_mm));
                end else begin
                    r_set_err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_ring   <= 1'b0;
            r_cnt    <= '0;
            r_snz_pm <= 1'b0;
            r_snz_hh <= '0;
            r_snz_mm <= '0;
        end else if (!i_arm) begin
            r_state <= ST_IDLE;
            r_ring  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: r_state <= ST_ARMED;
                ST_ARMED: begin
                    if (w_alarm_hit) begin
                        r_state <= ST_RINGING;
                        r_ring  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                ST_RINGING: begin
                    if (i_stop) begin
                        r_state <= ST_ARMED;
                        r_ring  <= 1'b0;
                    end else if (i_snooze) begin
                        r_state  <= ST_SNOOZE;
                        r_ring   <= 1'b0;
                        r_snz_pm <= w_nxt_pm;
                        r_snz_hh <= w_nxt_hh;
                        r_snz_mm <= w_nxt_mm;
                    end else if (i_ena) begin
                        if (r_cnt == CW'(RING_SECS - 1)) begin
                            r_state <= ST_ARMED;
                            r_ring  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (i_stop) begin
                        r_state <= ST_ARMED;
                    end else if (w_snz_hit) begin
                        r_state <= ST_RINGING;
                        r_ring  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef CLOCK_ALARM_HOURLY_CHIME_EN
    logic r_chime;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_chime <= 1'b0;
        end else begin
            r_chime <= i_ena && w_cur_valid && (w_cur_mm == '0) && (w_cur_ss == '0);
        end
    end

    assign o_chime = r_chime;
`endif

    assign o_set_ready = !i_rst && w_ready;
    assign o_set_err   = r_set_err;
    assign o_ring      = r_ring;
    assign o_state     = r_state;
    assign o_alarm_hh  = bin_to_bcd(7'(r_al_hh));
    assign o_alarm_mm  = bin_to_bcd(7'(r_al_mm));
    assign o_alarm_pm  = r_al_pm;

endmodule

// File: tb/tb_clock_alarm.sv
// Self-checking bench for clock_alarm: directed scenarios then random traffic against a minute-of-day model.
module tb_clock_alarm;

    localparam int unsigned RING_SECS  = 60;
    localparam int unsigned SNOOZE_MIN = 5;

    logic       i_clk = 1'b0;
    logic       i_rst, i_ena, i_pm;
    logic [7:0] i_hh, i_mm, i_ss;
    logic       i_set_valid, i_set_pm;
    logic [7:0] i_set_hh, i_set_mm;
    logic       o_set_ready, o_set_err;
    logic       i_arm, i_stop, i_snooze;
    logic       o_ring;
    logic [1:0] o_state;
    logic [7:0] o_alarm_hh, o_alarm_mm;
    logic       o_alarm_pm;
`ifdef CLOCK_ALARM_HOURLY_CHIME_EN
    logic       o_chime;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: time handled as minute-of-day 0..1439 (PM adds 720).
    int         m_state = 0;
    int         m_ticks = 0;
    int         m_snz_min = 0;
    bit         m_ring = 0, m_err = 0, m_chime = 0;
    logic [7:0] m_al_hh = 8'h00, m_al_mm = 8'h00;
    bit         m_al_pm = 0;

    clock_alarm #(.RING_SECS(RING_SECS), .SNOOZE_MIN(SNOOZE_MIN)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_ena       (i_ena),
        .i_pm        (i_pm),
        .i_hh        (i_hh),
        .i_mm        (i_mm),
        .i_ss        (i_ss),
        .i_set_valid (i_set_valid),
        .i_set_hh    (i_set_hh),
        .i_set_mm    (i_set_mm),
        .i_set_pm    (i_set_pm),
        .o_set_ready (o_set_ready),
        .o_set_err   (o_set_err),
        .i_arm       (i_arm),
        .i_stop      (i_stop),
        .i_snooze    (i_snooze),
        .o_ring      (o_ring),
        .o_state     (o_state),
        .o_alarm_hh  (o_alarm_hh),
        .o_alarm_mm  (o_alarm_mm),
        .o_alarm_pm  (o_alarm_pm)
`ifdef CLOCK_ALARM_HOURLY_CHIME_EN
        ,
        .o_chime     (o_chime)
`endif
    );

    always #5 i_clk = ~i_clk;

    function automatic bit dec(input logic [7:0] b, input int lim, output int v);
        int t, u;
        t = int'(b[7:4]);
        u = int'(b[3:0]);
        v = t * 10 + u;
        return (t <= 9) && (u <= 9) && (v <= lim);
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic int alarm_min();
        int h, m;
        bit ok;
        ok = dec(m_al_hh, 11, h);
        ok = dec(m_al_mm, 59, m) && ok;
        return int'(m_al_pm) * 720 + h * 60 + m;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        int h, mi, s, sh, sm, cmin;
        bit okh, okm, oks, cok, tick_ok;
        int n_state, n_ticks, n_snz;
        bit n_ring, n_err, n_chime, n_al_pm;
        logic [7:0] n_al_hh, n_al_mm;
        n_state = m_state; n_ticks = m_ticks; n_snz = m_snz_min;
        n_err = 0; n_chime = 0;
        n_al_hh = m_al_hh; n_al_mm = m_al_mm; n_al_pm = m_al_pm;
        okh = dec(i_hh, 11, h);
        okm = dec(i_mm, 59, mi);
        oks = dec(i_ss, 59, s);
        cok = okh && okm && oks;
        cmin = int'(i_pm) * 720 + h * 60 + mi;
        tick_ok = i_ena && cok && (s == 0);
        if (i_rst) begin
            n_state = 0; n_ticks = 0; n_snz = 0;
            n_al_hh = 8'h00; n_al_mm = 8'h00; n_al_pm = 0;
        end else begin
            n_chime = i_ena && cok && (mi == 0) && (s == 0);
            if (i_set_valid && m_state < 2) begin
                okh = dec(i_set_hh, 11, sh);
                okm = dec(i_set_mm, 59, sm);
                if (okh && okm) begin
                    n_al_hh = i_set_hh; n_al_mm = i_set_mm; n_al_pm = i_set_pm;
                end else begin
                    n_err = 1;
                end
            end
            if (!i_arm) n_state = 0;
            else case (m_state)
                0: n_state = 1;
                1: if (tick_ok && cmin == alarm_min()) begin n_state = 2; n_ticks = 0; end
                2: if (i_stop) n_state = 1;
                   else if (i_snooze) begin n_state = 3; n_snz = (cmin + SNOOZE_MIN) % 1440; end
                   else if (i_ena) begin
                       n_ticks = m_ticks + 1;
                       if (n_ticks == RING_SECS) n_state = 1;
                   end
                default: if (i_stop) n_state = 1;
                         else if (tick_ok && cmin == m_snz_min) begin n_state = 2; n_ticks = 0; end
            endcase
        end
        n_ring = (n_state == 2);
        @(posedge i_clk);
        #1;
        m_state = n_state; m_ticks = n_ticks; m_snz_min = n_snz;
        m_ring = n_ring; m_err = n_err; m_chime = n_chime;
        m_al_hh = n_al_hh; m_al_mm = n_al_mm; m_al_pm = n_al_pm;
        check("state", 8'(o_state), 8'(m_state));
        check("ring", 8'(o_ring), 8'(m_ring));
        check("set_err", 8'(o_set_err), 8'(m_err));
        check("set_ready", 8'(o_set_ready), 8'(!i_rst && m_state < 2));
        check("alarm_hh", o_alarm_hh, m_al_hh);
        check("alarm_mm", o_alarm_mm, m_al_mm);
        check("alarm_pm", 8'(o_alarm_pm), 8'(m_al_pm));
`ifdef CLOCK_ALARM_HOURLY_CHIME_EN
        check("chime", 8'(o_chime), 8'(m_chime));
`endif
    endtask

    task automatic set_time(input bit pm, input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss);
        i_pm = pm; i_hh = hh; i_mm = mm; i_ss = ss;
    endtask

    task automatic drive_min(input int mt);
        i_pm = (mt >= 720);
        i_hh = to_bcd((mt % 720) / 60);
        i_mm = to_bcd(mt % 60);
    endtask

    task automatic load(input logic [7:0] hh, input logic [7:0] mm, input bit pm);
        i_set_valid = 1; i_set_hh = hh; i_set_mm = mm; i_set_pm = pm;
        tick();
        i_set_valid = 0;
    endtask

    task automatic ena_tick();
        i_ena = 1;
        tick();
        i_ena = 0;
    endtask

    initial begin
        int r;
        bit tvalid;
        i_rst = 1; i_ena = 0; i_arm = 0; i_stop = 0; i_snooze = 0;
        i_set_valid = 0; i_set_hh = 8'h00; i_set_mm = 8'h00; i_set_pm = 0;
        set_time(0, 8'h00, 8'h00, 8'h01);
        tick();
        tick();
        i_rst = 0;
        tick();

        load(8'h07, 8'h30, 0);
        load(8'h12, 8'h30, 0);
        tick();
        i_arm = 1;
        tick();
        set_time(1, 8'h07, 8'h30, 8'h00); ena_tick();
        set_time(0, 8'h07, 8'h30, 8'h01); ena_tick();
        set_time(0, 8'h23, 8'h30, 8'h00); ena_tick();
        set_time(0, 8'h07, 8'h94, 8'h00); ena_tick();
        set_time(0, 8'h07, 8'h30, 8'h00); ena_tick();
        set_time(0, 8'h07, 8'h31, 8'h00);
        repeat (RING_SECS) begin ena_tick(); tick(); end
        tick();

        set_time(0, 8'h07, 8'h30, 8'h00); ena_tick();
        load(8'h05, 8'h00, 0);
        i_stop = 1; i_snooze = 1; tick(); i_stop = 0; i_snooze = 0;
        ena_tick();
        i_arm = 0; tick(); i_arm = 1; tick(); tick();

        load(8'h11, 8'h58, 1);
        set_time(1, 8'h11, 8'h58, 8'h00); ena_tick();
        i_snooze = 1; tick(); i_snooze = 0;
        set_time(0, 8'h00, 8'h02, 8'h00); ena_tick();
        set_time(0, 8'h00, 8'h03, 8'h00); ena_tick();
        tick();
        i_rst = 1; tick(); i_rst = 0; tick();
        set_time(0, 8'h03, 8'h00, 8'h00); ena_tick(); tick();

        for (int k = 0; k < 3000; k++) begin
            r = $urandom_range(0, 99);
            tvalid = 1;
            if (r < 30) drive_min(alarm_min());
            else if (r < 55) drive_min(m_snz_min);
            else if (r < 90) drive_min($urandom_range(0, 1439));
            else begin
                i_pm = 1'($urandom); i_hh = 8'($urandom); i_mm = 8'($urandom);
                tvalid = 0;
            end
            i_ss = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h00;
            i_ena       = 1'($urandom);
            i_arm       = ($urandom_range(0, 49) != 0);
            i_stop      = ($urandom_range(0, 199) == 0);
            i_snooze    = tvalid && ($urandom_range(0, 99) == 0);
            i_rst       = ($urandom_range(0, 499) == 0);
            i_set_valid = ($urandom_range(0, 29) == 0);
            i_set_hh    = $urandom_range(0, 1) ? to_bcd($urandom_range(0, 11)) : 8'($urandom);
            i_set_mm    = $urandom_range(0, 1) ? to_bcd($urandom_range(0, 59)) : 8'($urandom);
            i_set_pm    = 1'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
